// File: rtl/pwm_multi_ch.sv
// rtl/pwm_multi_ch.sv - multi-channel PWM with debounced duty buttons
// Duty changes land in a shadow register and reach the outputs only at period boundaries.
module pwm_multi_ch #(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 8,
  parameter int PERIOD    = 100,
  parameter int STEP      = 10,
  parameter int DUTY_INIT = 50,
  parameter int DEB_DIV   = 250000,
  localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic                inc_btn,
  input  logic                dec_btn,
  input  logic [SEL_W-1:0]    ch_sel,
  input  logic                duty_wr_en,
  input  logic [WIDTH-1:0]    duty_wr_data,
  output logic [WIDTH-1:0]    duty_rd,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick
);

  localparam int DIV_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DEB_DIV - 1);
  localparam logic [WIDTH-1:0] PERIOD_W  = WIDTH'(PERIOD);
  localparam logic [WIDTH-1:0] PERIOD_M1 = WIDTH'(PERIOD - 1);
  localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
  localparam logic [WIDTH:0]   STEP_X    = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] INIT_W    = WIDTH'(DUTY_INIT);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  logic [DIV_W-1:0]    div_q, div_d;
  logic [1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]          deb1_q, deb1_d, deb2_q, deb2_d;
  logic                slow_en;
  logic [1:0]          press;

  logic [WIDTH-1:0]    shadow_q [CHANNELS];
  logic [WIDTH-1:0]    shadow_d [CHANNELS];
  logic [WIDTH-1:0]    active_q [CHANNELS];
  logic [WIDTH-1:0]    active_d [CHANNELS];
  logic [WIDTH-1:0]    cur_duty, new_duty;
  logic [WIDTH:0]      inc_sum;

  logic [WIDTH-1:0]    cnt_q, cnt_d;
  dir_e                dir_q, dir_d;
  logic                mode_q, mode_d;
  logic                en_q, en_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                boundary, start;

  // Index 0 = inc, index 1 = dec; both buttons share one divider so simultaneous presses pulse together.
  always_comb begin
    slow_en = (div_q == DIV_LAST);
    div_d   = slow_en ? '0 : div_q + 1'b1;
    sync1_d = {dec_btn, inc_btn};
    sync2_d = sync1_q;
    deb1_d  = slow_en ? sync2_q : deb1_q;
    deb2_d  = slow_en ? deb1_q  : deb2_q;
    press   = deb1_q & ~deb2_q & {2{slow_en}};
  end

  always_comb begin
    cur_duty = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel == SEL_W'(i)) cur_duty = shadow_q[i];
    end
    duty_rd = cur_duty;

    inc_sum = {1'b0, cur_duty} + STEP_X;
    if (duty_wr_en)
      new_duty = (duty_wr_data > PERIOD_W) ? PERIOD_W : duty_wr_data;
    else if (press[0])
      new_duty = (inc_sum > {1'b0, PERIOD_W}) ? PERIOD_W : inc_sum[WIDTH-1:0];
    else
      new_duty = (cur_duty >= STEP_W) ? cur_duty - STEP_W : '0;

    for (int i = 0; i < CHANNELS; i++) begin
      shadow_d[i] = shadow_q[i];
      if ((duty_wr_en || press[0] || press[1]) && ch_sel == SEL_W'(i))
        shadow_d[i] = new_duty;
    end
  end

  always_comb begin
    boundary = en & (mode_q ? (dir_q == DIR_DOWN && cnt_q == '0) : (cnt_q == PERIOD_M1));
    start    = en & ~en_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    en_d     = en;
    active_d = active_q;

    if (!en) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (boundary) begin
      cnt_d    = '0;
      dir_d    = DIR_UP;
      mode_d   = mode;
      active_d = shadow_q;
    end else if (!mode_q) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q == PERIOD_M1) dir_d = DIR_DOWN;
      else                    cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end

    if (start) active_d = shadow_q;

    // On the first enabled cycle the fresh shadow value must already drive the compare.
    for (int i = 0; i < CHANNELS; i++)
      pwm_d[i] = en & (cnt_q < (start ? shadow_q[i] : active_q[i]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      deb1_q  <= '0;
      deb2_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_UP;
      mode_q  <= 1'b0;
      en_q    <= 1'b0;
      pwm_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= INIT_W;
        active_q[i] <= INIT_W;
      end
    end else begin
      div_q    <= div_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      deb1_q   <= deb1_d;
      deb2_q   <= deb2_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
      en_q     <= en_d;
      pwm_q    <= pwm_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_tick = boundary;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb/tb_pwm_multi_ch.sv - randomized bench for pwm_multi_ch against a period-phase model
module tb_pwm_multi_ch;
  localparam int CH = 2, W = 8, P = 10, STP = 1, DINIT = 5, DDIV = 2;

  logic          clk = 1'b0;
  logic          rst, en, mode, inc_btn, dec_btn, duty_wr_en;
  logic [0:0]    ch_sel;
  logic [W-1:0]  duty_wr_data, duty_rd;
  logic [CH-1:0] pwm_out;
  logic          period_tick;

  pwm_multi_ch #(.CHANNELS(CH), .WIDTH(W), .PERIOD(P), .STEP(STP),
                 .DUTY_INIT(DINIT), .DEB_DIV(DDIV)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .inc_btn(inc_btn), .dec_btn(dec_btn),
    .ch_sel(ch_sel), .duty_wr_en(duty_wr_en), .duty_wr_data(duty_wr_data),
    .duty_rd(duty_rd), .pwm_out(pwm_out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: position within the current period, not an up/down counter.
  int          m_phase;
  bit          m_mode, m_en_prev;
  int          m_active [CH];
  int          m_shadow [CH];
  bit [CH-1:0] m_pwm;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int plen(input bit md);
    return md ? 2 * P : P;
  endfunction

  function automatic int cval(input int ph, input bit md);
    if (!md) return ph;
    return (ph < P) ? ph : 2 * P - 1 - ph;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_mode = 0; m_en_prev = 0; m_pwm = '0;
    for (int i = 0; i < CH; i++) begin
      m_active[i] = DINIT;
      m_shadow[i] = DINIT;
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle(input bit chk_rd);
    bit          last, first;
    bit [CH-1:0] np;
    int          used;
    #1;
    last  = en && (m_phase == plen(m_mode) - 1);
    first = en && !m_en_prev;
    chk("pwm_out", pwm_out, m_pwm);
    chk("period_tick", period_tick, last);
    if (chk_rd) chk("duty_rd", duty_rd, m_shadow[ch_sel]);
    for (int i = 0; i < CH; i++) begin
      used  = first ? m_shadow[i] : m_active[i];
      np[i] = en && (cval(m_phase, m_mode) < used);
    end
    if (first) for (int i = 0; i < CH; i++) m_active[i] = m_shadow[i];
    if (!en) m_phase = 0;
    else if (last) begin
      m_phase = 0;
      m_mode  = mode;
      for (int i = 0; i < CH; i++) m_active[i] = m_shadow[i];
    end else m_phase++;
    if (duty_wr_en) m_shadow[ch_sel] = (duty_wr_data > P) ? P : int'(duty_wr_data);
    m_pwm     = np;
    m_en_prev = en;
    @(negedge clk);
  endtask

  // One physical press: hold, release, let the debouncer settle, then check the shadow.
  task automatic press(input bit inc, input bit dec, input int hold);
    inc_btn = inc; dec_btn = dec;
    repeat (hold) cycle(0);
    inc_btn = 0; dec_btn = 0;
    repeat (10) cycle(0);
    if (inc)      m_shadow[ch_sel] = (m_shadow[ch_sel] + STP > P) ? P : m_shadow[ch_sel] + STP;
    else if (dec) m_shadow[ch_sel] = (m_shadow[ch_sel] >= STP) ? m_shadow[ch_sel] - STP : 0;
    cycle(1);
  endtask

  initial begin
    rst = 1; en = 0; mode = 0; inc_btn = 0; dec_btn = 0; ch_sel = 0;
    duty_wr_en = 0; duty_wr_data = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    #1;
    chk("reset_pwm", pwm_out, 0);
    chk("reset_tick", period_tick, 0);
    chk("reset_duty_rd0", duty_rd, DINIT);
    ch_sel = 1; #1;
    chk("reset_duty_rd1", duty_rd, DINIT);
    ch_sel = 0;
    @(negedge clk);

    rst = 0; en = 1; mode = 0;
    repeat (22) cycle(1);
    #3 rst = 1;
    #1 chk("async_reset_pwm", pwm_out, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    repeat (25) cycle(1);

    ch_sel = 1;
    repeat (3) cycle(1);
    duty_wr_en = 1; duty_wr_data = 8'd3;
    cycle(1);
    duty_wr_en = 0;
    repeat (30) cycle(1);

    en = 0; ch_sel = 0;
    repeat (4) cycle(1);
    press(1, 0, 40);
    chk("held_press_once", duty_rd, 6);
    repeat (5) press(1, 0, 10);
    en = 1;
    repeat (25) cycle(1);
    en = 0;
    repeat (12) press(0, 1, 10);
    en = 1;
    repeat (25) cycle(1);
    en = 0;

    duty_wr_en = 1; duty_wr_data = 8'd2; inc_btn = 1;
    repeat (12) cycle(0);
    duty_wr_en = 0; inc_btn = 0;
    repeat (10) cycle(0);
    cycle(1);
    press(1, 1, 10);
    chk("inc_dec_together", duty_rd, 3);
    duty_wr_en = 1; duty_wr_data = 8'd200;
    cycle(1);
    duty_wr_en = 0;
    cycle(1);

    en = 1; duty_wr_en = 1; duty_wr_data = 8'd3;
    cycle(1);
    duty_wr_en = 0;
    repeat (5) cycle(1);
    mode = 1;
    repeat (60) cycle(1);

    repeat (600) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      duty_wr_en   = ($urandom_range(0, 5) == 0);
      duty_wr_data = ($urandom_range(0, 3) == 0) ? W'($urandom_range(11, 255))
                                                 : W'($urandom_range(0, 10));
      ch_sel       = 1'($urandom_range(0, 1));
      cycle(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
